dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 15 +
 rtl/dmem_arbiter_rr_arb2.sv | 22 ++
 rtl/dmem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
// Holds the FSM state encoding, the requester indices and the default lock bound.
package dmem_arbiter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_FI   = 1'b1;

  localparam int LOCK_MAX_DEFAULT = 8;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin selector: on contention, the requester that was not
// granted most recently wins. Output is one-hot (bit 0 core, bit 1 fault injector).
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // One-hot grant selection from the eligible requests and last-grant pointer
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == REQ_FI) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a core and a fault injector onto one single-port data memory,
// with round-robin fairness, bounded bus locking and a one-cycle read wait.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 9,
  parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic              c_lock,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              f_req,
  input  logic              f_we,
  input  logic              f_lock,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [DATA_W-1:0] f_wdata,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              wr,
  output logic              rd,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              lock_err
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  state_t             state_r, state_nxt;
  logic               rd_owner_r;
  logic               last_r;
  logic               lock_active_r;
  logic               lock_owner_r;
  logic               lock_err_r;
  logic [CNT_W-1:0]   lock_cnt_r;

  logic               owner_lock;
  logic               lock_rel;
  logic               locked;
  logic               lock_to;
  logic [CNT_W-1:0]   cnt_inc;
  logic [1:0]         elig;
  logic [1:0]         arb_gnt;
  logic [1:0]         grant;
  logic               any_gnt;
  logic               sel;
  logic               sel_we;
  logic               sel_lock;
  logic               rvalid_slot;

  // An owner dropping lock in IDLE releases it for that very cycle's arbitration
  assign owner_lock = (lock_owner_r == REQ_FI) ? f_lock : c_lock;
  assign lock_rel   = lock_active_r && (state_r == IDLE) && !owner_lock;
  assign locked     = lock_active_r && !lock_rel;
  assign cnt_inc    = lock_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
  assign lock_to    = locked && (cnt_inc >= CNT_W'(LOCK_MAX));

  assign elig[0] = c_req && (!locked || (lock_owner_r == REQ_CORE));
  assign elig[1] = f_req && (!locked || (lock_owner_r == REQ_FI));

  rr_arb2 u_rr (
    .req  (elig),
    .last (last_r),
    .gnt  (arb_gnt)
  );

  // Grant qualification and memory-side mux from the selected requester
  always_comb begin
    grant = 2'b00;
    if (reset && (state_r == IDLE)) begin
      grant = arb_gnt;
    end else begin
      grant = 2'b00;
    end
    any_gnt  = |grant;
    sel      = grant[1];
    sel_we   = sel ? f_we : c_we;
    sel_lock = sel ? f_lock : c_lock;
    wr       = any_gnt && sel_we;
    rd       = any_gnt && !sel_we;
    if (any_gnt) begin
      addr    = sel ? f_addr : c_addr;
      wr_data = sel ? f_wdata : c_wdata;
    end else begin
      addr    = {ADDR_W{1'b0}};
      wr_data = {DATA_W{1'b0}};
    end
  end

  assign c_gnt       = grant[0];
  assign f_gnt       = grant[1];
  assign rvalid_slot = reset && (state_r == RD_WAIT);
  assign c_rvalid    = rvalid_slot && (rd_owner_r == REQ_CORE);
  assign f_rvalid    = rvalid_slot && (rd_owner_r == REQ_FI);
  assign c_rdata     = c_rvalid ? rd_data : {DATA_W{1'b0}};
  assign f_rdata     = f_rvalid ? rd_data : {DATA_W{1'b0}};
  assign busy        = reset && ((state_r != IDLE) || lock_active_r);
  assign lock_err    = lock_err_r;

  // Next-state logic: a granted read spends exactly one cycle waiting for data
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (any_gnt && !sel_we) begin
          state_nxt = RD_WAIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      RD_WAIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, round-robin pointer and lock bookkeeping
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= IDLE;
      rd_owner_r    <= REQ_CORE;
      last_r        <= REQ_FI;
      lock_active_r <= 1'b0;
      lock_owner_r  <= REQ_CORE;
      lock_cnt_r    <= {CNT_W{1'b0}};
      lock_err_r    <= 1'b0;
    end else begin
      state_r <= state_nxt;
      if (any_gnt) begin
        last_r <= sel;
      end
      if (any_gnt && !sel_we) begin
        rd_owner_r <= sel;
      end
      if (lock_to) begin
        // Forced release hands priority to the requester that was locked out
        lock_active_r <= 1'b0;
        lock_cnt_r    <= {CNT_W{1'b0}};
        lock_err_r    <= 1'b1;
        last_r        <= lock_owner_r;
      end else if (locked) begin
        lock_cnt_r <= cnt_inc;
      end else if (any_gnt && sel_lock) begin
        lock_active_r <= 1'b1;
        lock_owner_r  <= sel;
        lock_cnt_r    <= {CNT_W{1'b0}};
      end else begin
        lock_active_r <= 1'b0;
        lock_cnt_r    <= {CNT_W{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: per-cycle grant/bus checks plus a
// scoreboard of expected read returns, backed by a simple memory model.
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_req, c_we, c_lock, f_req, f_we, f_lock;
  logic [AW-1:0] c_addr, f_addr, addr;
  logic [DW-1:0] c_wdata, f_wdata, c_rdata, f_rdata, wr_data;
  logic [DW-1:0] rd_data = 32'h0;
  logic          c_gnt, c_rvalid, f_gnt, f_rvalid, wr, rd, busy, lock_err;

  typedef struct packed {
    logic          who;
    logic [DW-1:0] data;
  } rv_t;

  rv_t           sb_q[$];
  logic [DW-1:0] mem     [0:511];
  logic [DW-1:0] exp_mem [0:511];
  int            n_checks = 0;
  int            n_pass   = 0;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .LOCK_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .f_req(f_req), .f_we(f_we), .f_lock(f_lock), .f_addr(f_addr), .f_wdata(f_wdata),
    .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .busy(busy), .lock_err(lock_err)
  );

  always #5 clk = ~clk;

  // Single-port memory with one-cycle read latency
  always @(posedge clk) begin
    if (wr) mem[addr] <= wr_data;
    rd_data <= rd ? mem[addr] : 32'h0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic sb_check();
    rv_t e;
    if (c_rvalid || f_rvalid) begin
      if (sb_q.size() == 0) begin
        check_eq("rv_unexpected", {62'h0, c_rvalid, f_rvalid}, 64'h0);
      end else begin
        e = sb_q.pop_front();
        check_eq("rv_who", {63'h0, f_rvalid}, {63'h0, e.who});
        check_eq("rv_other", {63'h0, (e.who ? c_rvalid : f_rvalid)}, 64'h0);
        check_eq("rv_data", {32'h0, (e.who ? f_rdata : c_rdata)}, {32'h0, e.data});
        check_eq("rv_other_data", {32'h0, (e.who ? c_rdata : f_rdata)}, 64'h0);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
    sb_check();
  endtask

  task automatic drive_c(input logic rq, input logic we, input logic lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    c_req = rq; c_we = we; c_lock = lk; c_addr = a; c_wdata = d;
  endtask

  task automatic drive_f(input logic rq, input logic we, input logic lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    f_req = rq; f_we = we; f_lock = lk; f_addr = a; f_wdata = d;
  endtask

  task automatic check_gnt(input string tag, input logic ec, input logic ef);
    check_eq({tag, "_cgnt"}, {63'h0, c_gnt}, {63'h0, ec});
    check_eq({tag, "_fgnt"}, {63'h0, f_gnt}, {63'h0, ef});
  endtask

  task automatic check_quiet(input string tag);
    check_gnt(tag, 1'b0, 1'b0);
    check_eq({tag, "_wr"}, {63'h0, wr}, 64'h0);
    check_eq({tag, "_rd"}, {63'h0, rd}, 64'h0);
    check_eq({tag, "_addr"}, {55'h0, addr}, 64'h0);
    check_eq({tag, "_wdata"}, {32'h0, wr_data}, 64'h0);
    check_eq({tag, "_rv"}, {62'h0, c_rvalid, f_rvalid}, 64'h0);
    check_eq({tag, "_rdata"}, {c_rdata, f_rdata}, 64'h0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i]     = 32'h1000_0000 + i;
      exp_mem[i] = 32'h1000_0000 + i;
    end
    reset = 1'b0;
    drive_c(1'b1, 1'b1, 1'b0, 9'h011, 32'h5555_AAAA);
    drive_f(1'b1, 1'b0, 1'b0, 9'h012, 32'h0);

    // Outputs stay quiet while reset is held, even with live requests
    for (int i = 0; i < 2; i++) begin
      cyc(); settle();
      check_quiet("rst");
      check_eq("rst_busy", {63'h0, busy}, 64'h0);
    end
    check_eq("rst_lockerr", {63'h0, lock_err}, 64'h0);

    // Single core write while idle
    cyc(); reset = 1'b1;
    drive_c(1'b1, 1'b1, 1'b0, 9'h010, 32'hDEAD_BEEF);
    drive_f(1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
    settle();
    check_gnt("wr1", 1'b1, 1'b0);
    check_eq("wr1_wr", {63'h0, wr}, 64'h1);
    check_eq("wr1_rd", {63'h0, rd}, 64'h0);
    check_eq("wr1_addr", {55'h0, addr}, 64'h010);
    check_eq("wr1_data", {32'h0, wr_data}, 64'hDEAD_BEEF);
    exp_mem[9'h010] = 32'hDEAD_BEEF;
    cyc(); drive_c(1'b0, 1'b0, 1'b0, 9'h0, 32'h0); settle();
    check_quiet("wr1_after");
    check_eq("wr1_busy", {63'h0, busy}, 64'h0);

    // Fresh reset, then simultaneous reads: core wins first
    cyc(); reset = 1'b0; settle();
    cyc(); reset = 1'b1;
    drive_c(1'b1, 1'b0, 1'b0, 9'h010, 32'h0);
    drive_f(1'b1, 1'b0, 1'b0, 9'h030, 32'h0);
    settle();
    check_gnt("rr1", 1'b1, 1'b0);
    check_eq("rr1_rd", {63'h0, rd}, 64'h1);
    check_eq("rr1_addr", {55'h0, addr}, 64'h010);
    sb_q.push_back('{who: 1'b0, data: exp_mem[9'h010]});
    cyc(); drive_c(1'b0, 1'b0, 1'b0, 9'h0, 32'h0); settle();
    check_gnt("rr1_wait", 1'b0, 1'b0);
    check_eq("rr1_wait_rd", {63'h0, rd}, 64'h0);
    check_eq("rr1_cvalid", {63'h0, c_rvalid}, 64'h1);
    check_eq("rr1_busy", {63'h0, busy}, 64'h1);
    cyc(); settle();
    check_gnt("rr2", 1'b0, 1'b1);
    check_eq("rr2_addr", {55'h0, addr}, 64'h030);
    sb_q.push_back('{who: 1'b1, data: exp_mem[9'h030]});
    cyc(); drive_f(1'b0, 1'b0, 1'b0, 9'h0, 32'h0); settle();
    check_eq("rr2_fvalid", {63'h0, f_rvalid}, 64'h1);

    // Fault injector locks the bus across a read and a write
    cyc(); drive_f(1'b1, 1'b0, 1'b1, 9'h020, 32'h0); settle();
    check_gnt("lk_rd", 1'b0, 1'b1);
    sb_q.push_back('{who: 1'b1, data: exp_mem[9'h020]});
    cyc();
    drive_c(1'b1, 1'b0, 1'b0, 9'h040, 32'h0);
    drive_f(1'b1, 1'b1, 1'b1, 9'h020, 32'h1234_5678);
    settle();
    check_gnt("lk_wait", 1'b0, 1'b0);
    cyc(); settle();
    check_gnt("lk_wr", 1'b0, 1'b1);
    check_eq("lk_wr_wr", {63'h0, wr}, 64'h1);
    check_eq("lk_wr_addr", {55'h0, addr}, 64'h020);
    exp_mem[9'h020] = 32'h1234_5678;
    cyc(); drive_f(1'b0, 1'b0, 1'b1, 9'h0, 32'h0); settle();
    check_gnt("lk_hold", 1'b0, 1'b0);
    check_eq("lk_busy", {63'h0, busy}, 64'h1);
    cyc(); drive_f(1'b0, 1'b0, 1'b0, 9'h0, 32'h0); settle();
    check_gnt("lk_rel", 1'b1, 1'b0);
    check_eq("lk_rel_addr", {55'h0, addr}, 64'h040);
    sb_q.push_back('{who: 1'b0, data: exp_mem[9'h040]});
    cyc(); drive_c(1'b0, 1'b0, 1'b0, 9'h0, 32'h0); settle();
    check_eq("lk_rel_cvalid", {63'h0, c_rvalid}, 64'h1);

    // Lock held past the limit: forced release and sticky error
    cyc(); drive_f(1'b1, 1'b1, 1'b1, 9'h050, 32'hF000_0000); settle();
    check_gnt("to_0", 1'b0, 1'b1);
    exp_mem[9'h050] = 32'hF000_0000;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      drive_c(1'b1, 1'b1, 1'b0, 9'h060, 32'hC0DE_0060);
      drive_f(1'b1, 1'b1, 1'b1, 9'(9'h050 + k), 32'hF000_0000 + k);
      settle();
      check_gnt($sformatf("to_%0d", k), 1'b0, 1'b1);
      check_eq($sformatf("to_%0d_err", k), {63'h0, lock_err}, 64'h0);
      exp_mem[9'h050 + k] = 32'hF000_0000 + k;
    end
    cyc(); drive_f(1'b1, 1'b1, 1'b1, 9'h059, 32'hF000_0009); settle();
    check_eq("to_err", {63'h0, lock_err}, 64'h1);
    check_gnt("to_core", 1'b1, 1'b0);
    exp_mem[9'h060] = 32'hC0DE_0060;
    cyc();
    drive_c(1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
    drive_f(1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
    settle();
    check_quiet("to_idle");
    check_eq("to_sticky", {63'h0, lock_err}, 64'h1);
    check_eq("to_busy", {63'h0, busy}, 64'h0);

    // Reset during the read wait aborts the return
    cyc(); drive_c(1'b1, 1'b0, 1'b0, 9'h010, 32'h0); settle();
    check_gnt("ab_rd", 1'b1, 1'b0);
    cyc(); drive_c(1'b0, 1'b0, 1'b0, 9'h0, 32'h0); reset = 1'b0; settle();
    check_eq("ab_rv", {63'h0, c_rvalid}, 64'h0);
    cyc(); reset = 1'b1; settle();
    check_quiet("ab_after");
    check_eq("ab_busy", {63'h0, busy}, 64'h0);
    check_eq("ab_err", {63'h0, lock_err}, 64'h0);

    // Continuous contention alternates core, f, core, f, ...
    for (int k = 0; k < 6; k++) begin
      if (k != 0) cyc();
      drive_c(1'b1, 1'b1, 1'b0, 9'h070, 32'hCC00_0000 + k);
      drive_f(1'b1, 1'b1, 1'b0, 9'h071, 32'hFF00_0000 + k);
      settle();
      check_gnt($sformatf("alt_%0d", k), (k % 2) == 0, (k % 2) == 1);
      if ((k % 2) == 0) exp_mem[9'h070] = 32'hCC00_0000 + k;
      else exp_mem[9'h071] = 32'hFF00_0000 + k;
    end
    cyc();
    drive_c(1'b1, 1'b0, 1'b0, 9'h070, 32'h0);
    drive_f(1'b1, 1'b0, 1'b0, 9'h071, 32'h0);
    settle();
    check_gnt("alt_rd_c", 1'b1, 1'b0);
    sb_q.push_back('{who: 1'b0, data: exp_mem[9'h070]});
    cyc(); drive_c(1'b0, 1'b0, 1'b0, 9'h0, 32'h0); settle();
    cyc(); settle();
    check_gnt("alt_rd_f", 1'b0, 1'b1);
    sb_q.push_back('{who: 1'b1, data: exp_mem[9'h071]});
    cyc(); drive_f(1'b0, 1'b0, 1'b0, 9'h0, 32'h0); settle();
    cyc(); settle();
    check_quiet("end_idle");
    check_eq("sb_empty", sb_q.size(), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
